// File: rtl/fft_pkg.sv
// Shared constants, read-FSM encoding and index bit reversal for the
// 8-point FFT output reorder stage.
package fft_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned N      = 8;
  localparam int unsigned LOG2N  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      r[i] = idx[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// N x DATA_W register file: one synchronous write port, one combinational read port.
module reorder_bank
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [LOG2N-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LOG2N-1:0]  raddr,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [N];

  // Contents are deliberately not reset; the full flags guard stale data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong buffer that turns bit-reversed FFT output frames into natural order,
// sustaining one sample per cycle.
module fft_bitrev_reorder
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sync,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  rd_state_e         state, state_nxt;
  logic [LOG2N-1:0]  wr_idx, wr_idx_nxt;
  logic [LOG2N-1:0]  rd_idx, rd_idx_nxt;
  logic              wr_bank, wr_bank_nxt;
  logic              rd_bank, rd_bank_nxt;
  logic [1:0]        full, full_nxt;
  logic              out_valid_nxt, out_last_nxt;
  logic [DATA_W-1:0] out_data_nxt;

  logic              rd_en_c;
  logic [LOG2N-1:0]  wr_addr_c;
  logic [DATA_W-1:0] rdata0_c, rdata1_c, rd_data_c;
  logic              we0_c, we1_c;

  assign we0_c     = clear && in_valid && !wr_bank;
  assign we1_c     = clear && in_valid &&  wr_bank;
  assign rd_data_c = rd_bank ? rdata1_c : rdata0_c;

  reorder_bank u_bank0 (
    .clk     (clk),
    .we      (we0_c),
    .waddr   (wr_addr_c),
    .wdata   (in_data),
    .raddr   (rd_idx),
    .rdata_c (rdata0_c)
  );

  reorder_bank u_bank1 (
    .clk     (clk),
    .we      (we1_c),
    .waddr   (wr_addr_c),
    .wdata   (in_data),
    .raddr   (rd_idx),
    .rdata_c (rdata1_c)
  );

  always_ff @(posedge clk) begin
    if (!clear) begin
      state     <= IDLE;
      wr_idx    <= '0;
      wr_bank   <= 1'b0;
      rd_idx    <= '0;
      rd_bank   <= 1'b0;
      full      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_idx    <= wr_idx_nxt;
      wr_bank   <= wr_bank_nxt;
      rd_idx    <= rd_idx_nxt;
      rd_bank   <= rd_bank_nxt;
      full      <= full_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_last  <= out_last_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wr_idx_nxt    = wr_idx;
    wr_bank_nxt   = wr_bank;
    rd_idx_nxt    = rd_idx;
    rd_bank_nxt   = rd_bank;
    full_nxt      = full;
    out_valid_nxt = 1'b0;
    out_data_nxt  = out_data;
    out_last_nxt  = 1'b0;
    wr_addr_c     = bitrev(wr_idx);

    // IDLE issues the first beat on the same edge it sees a full bank, so
    // natural index 0 appears one edge after the frame completes.
    rd_en_c = (state == READ) || full[rd_bank];

    if (rd_en_c) begin
      out_valid_nxt = 1'b1;
      out_data_nxt  = rd_data_c;
      out_last_nxt  = (rd_idx == LAST_IDX);
      if (rd_idx == LAST_IDX) begin
        full_nxt[rd_bank] = 1'b0;
        rd_bank_nxt       = ~rd_bank;
        rd_idx_nxt        = '0;
        state_nxt         = full[~rd_bank] ? READ : IDLE;
      end else begin
        rd_idx_nxt = rd_idx + LOG2N'(1);
        state_nxt  = READ;
      end
    end

    // Writer runs after the reader so both flag updates land on the same edge.
    if (in_valid) begin
      if (in_sync) begin
        wr_addr_c  = '0;
        wr_idx_nxt = LOG2N'(1);
      end else if (wr_idx == LAST_IDX) begin
        full_nxt[wr_bank] = 1'b1;
        wr_bank_nxt       = ~wr_bank;
        wr_idx_nxt        = '0;
      end else begin
        wr_idx_nxt = wr_idx + LOG2N'(1);
      end
    end
  end

endmodule
